render_rect: RTL and testbench
==============================

Name: render_rect

Overview:
- Parametrised rectangle rasteriser; successor to the fixed-size box drawer.
- Accepts one command at a time: origin, runtime width/height, colour, fill/outline mode.
- Emits one pixel write per cycle on a valid/ready pixel port with backpressure.
- Sits between game/board logic and the VGA adapter write port. The VGA adapter is instantiated at top level, not inside this block.

Parameters:
- X_W, 10, pixel X coordinate and rect width bit width
- Y_W, 9, pixel Y coordinate and rect height bit width
- COLOR_W, 9, colour width (RRR_GGG_BBB at default)
- SCREEN_W, 640, visible width; used only with RENDER_CLIP_EN
- SCREEN_H, 480, visible height; used only with RENDER_CLIP_EN

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x0  in  X_W  top-left X
- cmd_y0  in  Y_W  top-left Y
- cmd_w  in  X_W  width in pixels (0 allowed)
- cmd_h  in  Y_W  height in pixels (0 allowed)
- cmd_color  in  COLOR_W  fill colour
- cmd_outline  in  1  0 = solid fill, 1 = one-pixel border only
- pix_valid  out  1  pixel write present
- pix_ready  in  1  sink accepts pixel
- pix_x  out  X_W  absolute X
- pix_y  out  Y_W  absolute Y
- pix_color  out  COLOR_W  latched colour
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, active-high): state IDLE; counters xc/yc = 0; latched command = 0; pix_valid = 0; busy = 0; done = 0; cmd_ready = 1 after reset deasserts. Reset mid-draw aborts immediately; no done pulse.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid, latch all cmd_* fields and clear xc/yc. Go to DRAW, or to DONE if cmd_w == 0 or cmd_h == 0.
  - DRAW: busy = 1, cmd_ready = 0. The current pixel is (xc, yc).
  - DONE: done = 1 for exactly one cycle, busy = 0, cmd_ready = 0. Always returns to IDLE.
- Latency: command accepted in cycle N means first pix_valid in cycle N+1. A zero-size command gives done in cycle N+1 and no pixels.
- Pixel emission:
  - pix_x = (x0 + xc) mod 2^X_W.
  - pix_y = (y0 + yc) mod 2^Y_W.
  - pix_color = latched colour.
  - pix_* are driven from registered state only; no combinational path from pix_ready to any output.
  - While pix_valid && !pix_ready: pix_x, pix_y, pix_color and pix_valid hold stable.
- Advance on pix_valid && pix_ready, or on a skipped pixel:
  - If xc < w-1: xc++.
  - Otherwise xc = 0 and yc++.
  - The transfer of (w-1, h-1) moves to DONE the next cycle.
- Raster order: row-major, left to right, top to bottom.
- Outline mode:
  - Only pixels with xc == 0, xc == w-1, yc == 0 or yc == h-1 are emitted.
  - On interior rows, after xc = 0 transfers, xc jumps directly to w-1 with no idle cycles.
  - Pixel count: w*h if w ≤ 2 or h ≤ 2, else 2w + 2(h-2).
- Throughput: one pixel per cycle when pix_ready is held high.
- Arithmetic: counters are X_W/Y_W wide. w-1 and h-1 are computed only when w, h ≠ 0.
- cmd_valid is ignored outside IDLE; it does not stall or corrupt an in-progress command.

Optional Feature:
- Macro RENDER_CLIP_EN.
- Defined:
  - Sums x0+xc and y0+yc are computed one bit wider.
  - A pixel with x ≥ SCREEN_W or y ≥ SCREEN_H is skipped: pix_valid low for that position, counters advance one position per cycle.
  - done still pulses when the command completes.
- Undefined: no clipping; coordinates wrap modulo 2^X_W / 2^Y_W. SCREEN_W and SCREEN_H are unused.

Test Plan:
- Fill 3x2 at (10,20), colour 9'h1C0, pix_ready=1 -> pixels (10,20)(11,20)(12,20)(10,21)(11,21)(12,21) on consecutive cycles starting N+1; done at N+7; cmd_ready high at N+8.
- Outline 4x3 at (0,0) -> 10 pixels: row 0 x=0..3, row 1 x=0 then x=3, row 2 x=0..3; no gap cycles.
- Fill 2x2 with pix_ready toggling 1,0,0,1,... -> exactly 4 transfers in raster order; pix_x/pix_y constant during stalls; done one cycle after the 4th transfer.
- cmd_w=0, cmd_h=5 -> no pix_valid; done pulses at N+1; busy never asserts.
- Fill 64x24 with reset asserted mid-draw (after the 100th pixel) -> pix_valid, busy, done go 0 asynchronously; no done pulse; cmd_ready=1 after release; a new 1x1 command completes normally.
- Fill 4x1 at (638,5):
  - With RENDER_CLIP_EN: pixels x=638,639 only; done at N+5.
  - Without: x=638,639,640,641; done at N+5.

Source files
------------

// File: rtl/render_rect_if.sv
// render_rect_if: command and pixel handshake bundle between board logic, render_rect and the VGA write port
interface render_rect_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int COLOR_W = 9
);
  logic cmd_valid;
  logic cmd_ready;
  logic [X_W-1:0] cmd_x0;
  logic [Y_W-1:0] cmd_y0;
  logic [X_W-1:0] cmd_w;
  logic [Y_W-1:0] cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic cmd_outline;
  logic pix_valid;
  logic pix_ready;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic busy;
  logic done;
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_outline, pix_ready,
    input cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
  );
  modport slave (
    input cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_outline, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
  );
endinterface

// File: rtl/render_rect.sv
// render_rect: rectangle rasteriser (fill or one-pixel outline), one pixel write per cycle with backpressure
// Optional feature macro RENDER_CLIP_EN: positions outside SCREEN_W x SCREEN_H are skipped instead of wrapping
module render_rect #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int COLOR_W = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic CLOCK_50,
  input logic reset,
  render_rect_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_nx;
  logic [X_W-1:0] x0, w, xc, xc_nx, wm1, px;
  logic [Y_W-1:0] y0, h, yc, yc_nx, hm1, py;
  logic [COLOR_W-1:0] color;
  logic outline, x_last, y_last, edge_row, emit, adv;
  assign wm1 = w - X_W'(1);
  assign hm1 = h - Y_W'(1);
  assign x_last = xc == wm1;
  assign y_last = yc == hm1;
  assign edge_row = yc == '0 || y_last;
`ifdef RENDER_CLIP_EN
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  assign sx = {1'b0, x0} + {1'b0, xc};
  assign sy = {1'b0, y0} + {1'b0, yc};
  assign emit = sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
  assign px = sx[X_W-1:0];
  assign py = sy[Y_W-1:0];
`else
  assign emit = 1'b1;
  assign px = x0 + xc;
  assign py = y0 + yc;
`endif
  assign adv = state == DRAW && (!emit || bus.pix_ready);
  // state register
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // command latch and raster position counters
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      w <= '0;
      h <= '0;
      color <= '0;
      outline <= 1'b0;
      xc <= '0;
      yc <= '0;
    end else if (state == IDLE && bus.cmd_valid) begin
      x0 <= bus.cmd_x0;
      y0 <= bus.cmd_y0;
      w <= bus.cmd_w;
      h <= bus.cmd_h;
      color <= bus.cmd_color;
      outline <= bus.cmd_outline;
      xc <= '0;
      yc <= '0;
    end else if (adv) begin
      xc <= xc_nx;
      yc <= yc_nx;
    end
  // next raster position (interior outline rows jump from the left edge straight to the right edge) and next state
  always_comb begin
    state_nx = state;
    xc_nx = x_last ? '0 : (outline && !edge_row && xc == '0) ? wm1 : xc + X_W'(1);
    yc_nx = x_last ? yc + Y_W'(1) : yc;
    if (state == IDLE && bus.cmd_valid) state_nx = (bus.cmd_w == '0 || bus.cmd_h == '0) ? DONE : DRAW;
    else if (state == DRAW && adv && x_last && y_last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // outputs come from registered state only, never from pix_ready
  always_comb begin
    bus.cmd_ready = state == IDLE;
    bus.busy = state == DRAW;
    bus.done = state == DONE;
    bus.pix_valid = state == DRAW && emit;
    bus.pix_x = px;
    bus.pix_y = py;
    bus.pix_color = color;
  end
endmodule

// File: tb/tb_render_rect.sv
// tb_render_rect: table-driven and randomized checks of render_rect against a pixel-list model
module tb_render_rect;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int C_W = 9;
`ifdef RENDER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  render_rect_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W)) bus();
  render_rect #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  int n_chk = 0;
  int n_pass = 0;
  logic [27:0] exp_q[$];
  typedef struct {
    int x0, y0, w, h, c;
    bit ol;
    int mode;
    int exp_n;
    int exp_done;
    string tag;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic build(input int x0, input int y0, input int w, input int h, input int c, input bit ol);
    int px, py;
    exp_q.delete();
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        if (ol && !(xx == 0 || xx == w - 1 || yy == 0 || yy == h - 1)) continue;
        px = x0 + xx;
        py = y0 + yy;
        if (CLIP && (px >= 640 || py >= 480)) continue;
        px = px % (1 << X_W);
        py = py % (1 << Y_W);
        exp_q.push_back({X_W'(px), Y_W'(py), C_W'(c)});
      end
  endtask

  task automatic issue(input int x0, input int y0, input int w, input int h, input int c, input bit ol, input string tag);
    @(negedge CLOCK_50);
    bus.cmd_x0 = X_W'(x0);
    bus.cmd_y0 = Y_W'(y0);
    bus.cmd_w = X_W'(w);
    bus.cmd_h = Y_W'(h);
    bus.cmd_color = C_W'(c);
    bus.cmd_outline = ol;
    bus.cmd_valid = 1'b1;
    chk({tag, " cmd_ready"}, int'(bus.cmd_ready), 1);
    @(negedge CLOCK_50);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run(input int x0, input int y0, input int w, input int h, input int c, input bit ol,
                     input int mode, input bit noise, input int exp_n, input int exp_done, input string tag);
    int got, done_at, last;
    bit st, saw_busy;
    logic [28:0] cur, hold;
    got = 0; done_at = 0; last = 0; st = 0; saw_busy = 0; hold = '0;
    build(x0, y0, w, h, c, ol);
    if (exp_n < 0) exp_n = exp_q.size();
    issue(x0, y0, w, h, c, ol, tag);
    for (int k = 1; k <= 2000 && done_at == 0; k++) begin
      if (k > 1) @(negedge CLOCK_50);
      bus.pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 1) : 1'($urandom_range(0, 1));
      bus.cmd_valid = noise && bus.busy;
      if (noise) begin
        bus.cmd_x0 = X_W'($urandom);
        bus.cmd_y0 = Y_W'($urandom);
        bus.cmd_w = X_W'($urandom_range(0, 3));
        bus.cmd_h = Y_W'($urandom_range(0, 3));
        bus.cmd_color = C_W'($urandom);
        bus.cmd_outline = 1'($urandom_range(0, 1));
      end
      #1;
      cur = {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color};
      if (st) chk({tag, " stall hold"}, int'(cur), int'(hold));
      if (bus.busy) saw_busy = 1'b1;
      if (bus.done) done_at = k;
      else if (bus.pix_valid && bus.pix_ready) begin
        if (got < exp_q.size()) chk({tag, " pixel"}, int'(cur[27:0]), int'(exp_q[got]));
        else chk({tag, " extra pixel"}, 1, 0);
        got++;
        last = k;
      end
      st = bus.pix_valid && !bus.pix_ready;
      hold = cur;
    end
    bus.cmd_valid = 1'b0;
    if (done_at == 0) chk({tag, " done timeout"}, 0, 1);
    chk({tag, " count"}, got, exp_n);
    chk({tag, " done cycle"}, done_at, exp_done > 0 ? exp_done : last + 1);
    chk({tag, " busy seen"}, int'(saw_busy), int'(w != 0 && h != 0));
    @(negedge CLOCK_50);
    #1;
    chk({tag, " done one cycle"}, int'(bus.done), 0);
    chk({tag, " cmd_ready after"}, int'(bus.cmd_ready), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.cmd_outline = 1'b0;
    bus.pix_ready = 1'b0;
    vecs[0] = '{10, 20, 3, 2, 9'h1C0, 1'b0, 0, 6, 7, "fill3x2"};
    vecs[1] = '{0, 0, 4, 3, 9'h03F, 1'b1, 0, 10, 11, "outline4x3"};
    vecs[2] = '{100, 50, 2, 2, 9'h155, 1'b0, 1, 4, 11, "stall2x2"};
    vecs[3] = '{7, 7, 0, 5, 9'h1FF, 1'b0, 0, 0, 1, "zero_w"};
    vecs[4] = '{7, 7, 5, 0, 9'h1FF, 1'b1, 0, 0, 1, "zero_h"};
    vecs[5] = '{1022, 510, 3, 3, 9'h0F0, 1'b0, 0, CLIP ? 0 : 9, 10, "corner3x3"};
    vecs[6] = '{638, 5, 4, 1, 9'h0AA, 1'b0, 0, CLIP ? 2 : 4, 5, "edge4x1"};
    vecs[7] = '{30, 40, 1, 1, 9'h111, 1'b1, 0, 1, 2, "dot"};
    vecs[8] = '{5, 5, 3, 3, 9'h0C3, 1'b1, 0, 8, 9, "outline3x3"};
    vecs[9] = '{200, 100, 5, 4, 9'h1A5, 1'b1, 2, 14, -1, "outline5x4rnd"};
    vecs[10] = '{1, 2, 1, 5, 9'h007, 1'b1, 0, 5, 6, "outline1x5"};
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("in reset pix_valid", int'(bus.pix_valid), 0);
    chk("in reset busy", int'(bus.busy), 0);
    reset = 1'b0;
    #1;
    chk("reset cmd_ready", int'(bus.cmd_ready), 1);
    chk("reset done", int'(bus.done), 0);
    chk("reset pix_valid", int'(bus.pix_valid), 0);
    foreach (vecs[i])
      run(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].ol,
          vecs[i].mode, 1'b0, vecs[i].exp_n, vecs[i].exp_done, vecs[i].tag);
    begin
      int n;
      bit saw_done;
      n = 0;
      saw_done = 1'b0;
      issue(0, 0, 64, 24, 9'h0F0, 1'b0, "abort");
      bus.pix_ready = 1'b1;
      for (int k = 1; k <= 300 && n < 100; k++) begin
        if (k > 1) @(negedge CLOCK_50);
        #1;
        if (bus.pix_valid) n++;
      end
      chk("abort progress", n, 100);
      @(posedge CLOCK_50);
      #2 reset = 1'b1;
      #1;
      chk("abort pix_valid", int'(bus.pix_valid), 0);
      chk("abort busy", int'(bus.busy), 0);
      chk("abort done", int'(bus.done), 0);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
        #1;
        if (bus.done || bus.pix_valid || bus.busy) saw_done = 1'b1;
        @(negedge CLOCK_50);
      end
      chk("abort quiet after release", int'(saw_done), 0);
      #1;
      chk("abort cmd_ready", int'(bus.cmd_ready), 1);
      run(3, 4, 1, 1, 9'h1AB, 1'b0, 0, 1'b0, 1, 2, "post_abort");
    end
    for (int i = 0; i < 25; i++)
      run($urandom_range(0, 500), $urandom_range(0, 300), $urandom_range(0, 12), $urandom_range(0, 8),
          $urandom_range(0, 511), 1'($urandom_range(0, 1)), 2, 1'b1, -1, -1, "rand");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
